// File: rtl/rv32_inst_encoder.sv
// Packs field-level RV32I requests into machine words and writes them to IMEM in order (accept -> encode -> write).
// Optional macro IMM_RANGE_CHECK_EN rejects out-of-range immediates; without it excess immediate bits are truncated.
module rv32_inst_encoder #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [2:0]        req_func3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_e;

  localparam logic [3:0] K_R     = 4'd0;
  localparam logic [3:0] K_I     = 4'd1;
  localparam logic [3:0] K_LOAD  = 4'd2;
  localparam logic [3:0] K_STORE = 4'd3;
  localparam logic [3:0] K_BR    = 4'd4;
  localparam logic [3:0] K_LUI   = 4'd5;
  localparam logic [3:0] K_AUIPC = 4'd6;
  localparam logic [3:0] K_JAL   = 4'd7;
  localparam logic [3:0] K_JALR  = 4'd8;
  localparam logic [3:0] K_END   = 4'd15;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        kind_q, kind_d;
  logic [2:0]        f3_q, f3_d;
  logic              alt_q, alt_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d, full_q, full_d, err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              fit12, fit13, fit21, upper_ok;

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s    = imm_q;
  assign fit12    = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fit13    = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
  assign fit21    = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
  assign upper_ok = (imm_q[11:0] == 12'h000);
`else
  assign fit12    = 1'b1;
  assign fit13    = 1'b1;
  assign fit21    = 1'b1;
  assign upper_ok = 1'b1;
`endif

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (kind_q)
      K_R: begin
        enc_word  = {(alt_q ? 7'b0100000 : 7'b0000000), rs2_q, rs1_q, f3_q, rd_q, OPC_R};
        enc_legal = !alt_q || (f3_q == 3'b000) || (f3_q == 3'b101);
      end
      K_I: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_I};
        // shifts carry the SRAI selector in funct7 and only a 5-bit shamt
        if ((f3_q == 3'b001) || (f3_q == 3'b101))
          enc_word[31:20] = {1'b0, alt_q, 5'b00000, imm_q[4:0]};
        enc_legal = (!alt_q || (f3_q == 3'b101)) && fit12;
      end
      K_LOAD: begin
        enc_word  = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_LOAD};
        enc_legal = (f3_q != 3'b011) && (f3_q != 3'b110) && (f3_q != 3'b111) && fit12;
      end
      K_STORE: begin
        enc_word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OPC_STORE};
        enc_legal = (f3_q <= 3'b010) && fit12;
      end
      K_BR: begin
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OPC_BR};
        enc_legal = (f3_q != 3'b010) && (f3_q != 3'b011) && !imm_q[0] && fit13;
      end
      K_LUI: begin
        enc_word  = {imm_q[31:12], rd_q, OPC_LUI};
        enc_legal = upper_ok;
      end
      K_AUIPC: begin
        enc_word  = {imm_q[31:12], rd_q, OPC_AUIPC};
        enc_legal = upper_ok;
      end
      K_JAL: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
        enc_legal = !imm_q[0] && fit21;
      end
      K_JALR: begin
        enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
        enc_legal = fit12;
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign req_ready   = (state_q == S_IDLE) && !done_q && !full_q;
  assign imem_we     = (state_q == S_WR);
  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign done        = done_q;
  assign full        = full_q;
  assign err_illegal = err_q;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    f3_d    = f3_q;
    alt_d   = alt_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          kind_d = req_kind;
          f3_d   = req_func3;
          alt_d  = req_alt;
          rd_d   = req_rd;
          rs1_d  = req_rs1;
          rs2_d  = req_rs2;
          imm_d  = req_imm;
          if (req_kind == K_END) done_d  = 1'b1;
          else                   state_d = S_ENC;
        end
      end
      S_ENC: begin
        wdata_d = enc_word;
        if (enc_legal) begin
          state_d = S_WR;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (imem_ready) begin
          count_d = count_q + CNT_ONE;
          // the pointer stops on the last slot so it never wraps
          if (count_q + CNT_ONE == DEPTH_C) full_d = 1'b1;
          else                              ptr_d  = ptr_q + PTR_ONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      kind_d  = 4'h0;
      f3_d    = 3'h0;
      alt_d   = 1'b0;
      rd_d    = 5'h0;
      rs1_d   = 5'h0;
      rs2_d   = 5'h0;
      imm_d   = 32'h0;
      wdata_d = 32'h0;
      ptr_d   = '0;
      count_d = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= 4'h0;
      f3_q    <= 3'h0;
      alt_q   <= 1'b0;
      rd_q    <= 5'h0;
      rs1_q   <= 5'h0;
      rs2_q   <= 5'h0;
      imm_q   <= 32'h0;
      wdata_q <= 32'h0;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      f3_q    <= f3_d;
      alt_q   <= alt_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed bench for rv32_inst_encoder with a 4-word IMEM region.
module tb_rv32_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clear, req_valid, req_ready, req_alt;
  logic [3:0]  req_kind;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        imem_we, imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic        done, full, err_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t legal_tab [10] = '{
    '{4'd1, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,         32'h40335293},
    '{4'd2, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 32'd8,         32'h00812203},
    '{4'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12,        32'h00512623},
    '{4'd3, 3'b000, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFF,  32'hFE510FA3},
    '{4'd4, 3'b001, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16,        32'h00209863},
    '{4'd5, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000,  32'h123453B7},
    '{4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF000,  32'hFFFFF097},
    '{4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF},
    '{4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC,  32'hFFDFF0EF},
    '{4'd8, 3'b111, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067}
  };

  vec_t illegal_tab [8] = '{
    '{4'd9,  3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0},
    '{4'd14, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0},
    '{4'd0,  3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0},
    '{4'd1,  3'b000, 1'b1, 5'd1, 5'd1, 5'd0, 32'd5, 32'h0},
    '{4'd2,  3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 32'h0},
    '{4'd3,  3'b100, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'h0},
    '{4'd4,  3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 32'h0},
    '{4'd7,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 32'h0}
  };

  rv32_inst_encoder #(.IMEM_DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_func3(req_func3), .req_alt(req_alt), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .done(done), .full(full),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Returns at the negedge right after the accepting edge, with req_valid dropped.
  task automatic send(input vec_t v, input int budget, output bit acc);
    @(negedge clk);
    req_kind = v.kind; req_func3 = v.f3; req_alt = v.alt;
    req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_we(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (imem_we) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                              input logic [31:0] imm);
    vec_t v;
    v = '{k, f3, alt, 5'd3, 5'd1, 5'd2, imm, 32'h0};
    if (k == 4'd1) v.rd = 5'd1;
    if (k == 4'd1) v.rs1 = 5'd0;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
    req_kind = '0; req_func3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    total++; if ({req_ready, imem_we, done, full, err_illegal} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000", {req_ready, imem_we, done, full, err_illegal}); end
    total++; if (count !== 9'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    bit acc, seen;
    send(mk(4'd0, 3'b000, 1'b0, 32'd0), 4, acc);
    total++; if (!acc || imem_we !== 1'b0) begin
      bad++; $display("FAIL add_n1: acc=%0b we=%b want acc=1 we=0", acc, imem_we); end
    @(negedge clk);
    total++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd0, 32'h002081B3}) begin
      bad++; $display("FAIL add_n2: we=%b addr=%0d data=%h want 1/0/002081b3", imem_we, imem_addr, imem_wdata); end
    @(negedge clk);
    total++; if ({imem_we, req_ready, count} !== {1'b0, 1'b1, 9'd1}) begin
      bad++; $display("FAIL add_done: we=%b rdy=%b count=%0d want 0/1/1", imem_we, req_ready, count); end
    send(mk(4'd0, 3'b000, 1'b1, 32'd0), 4, acc);
    wait_we(4, seen);
    total++; if ({seen, imem_addr, imem_wdata} !== {1'b1, 8'd1, 32'h402081B3}) begin
      bad++; $display("FAIL sub: seen=%b addr=%0d data=%h want 1/1/402081b3", seen, imem_addr, imem_wdata); end
    send(mk(4'd1, 3'b000, 1'b0, 32'd5), 4, acc);
    wait_we(4, seen);
    total++; if ({seen, imem_addr, imem_wdata} !== {1'b1, 8'd2, 32'h00500093}) begin
      bad++; $display("FAIL addi: seen=%b addr=%0d data=%h want 1/2/00500093", seen, imem_addr, imem_wdata); end
    @(negedge clk);
    total++; if (count !== 9'd3) begin bad++; $display("FAIL count3: got %0d want 3", count); end
  endtask

  task automatic test_illegal_branch();
    bit acc, seen;
    send(mk(4'd4, 3'b000, 1'b0, 32'hFFFFFFFD), 4, acc);
    wait_we(4, seen);
    total++; if ({acc, seen, err_illegal, req_ready, count} !== {1'b1, 1'b0, 1'b1, 1'b1, 9'd3}) begin
      bad++; $display("FAIL br_odd: acc=%b seen=%b err=%b rdy=%b count=%0d want 1/0/1/1/3",
                      acc, seen, err_illegal, req_ready, count); end
  endtask

  task automatic test_fill();
    bit acc, seen;
    send(mk(4'd4, 3'b000, 1'b0, 32'hFFFFFFFC), 4, acc);
    wait_we(4, seen);
    total++; if ({seen, imem_addr, imem_wdata} !== {1'b1, 8'd3, 32'hFE208EE3}) begin
      bad++; $display("FAIL branch: seen=%b addr=%0d data=%h want 1/3/fe208ee3", seen, imem_addr, imem_wdata); end
    @(negedge clk);
    total++; if ({full, req_ready, count} !== {1'b1, 1'b0, 9'd4}) begin
      bad++; $display("FAIL full: full=%b rdy=%b count=%0d want 1/0/4", full, req_ready, count); end
    send(mk(4'd0, 3'b000, 1'b0, 32'd0), 4, acc);
    total++; if ({acc, imem_we, count} !== {1'b0, 1'b0, 9'd4}) begin
      bad++; $display("FAIL fifth: acc=%b we=%b count=%0d want 0/0/4", acc, imem_we, count); end
    do_clear();
    total++; if ({full, err_illegal, req_ready, count} !== {1'b0, 1'b0, 1'b1, 9'd0}) begin
      bad++; $display("FAIL clear: full=%b err=%b rdy=%b count=%0d want 0/0/1/0", full, err_illegal, req_ready, count); end
  endtask

  task automatic test_encodings();
    bit acc, seen;
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 0) do_clear();
      send(legal_tab[i], 4, acc);
      wait_we(4, seen);
      total++; if ({acc, seen, imem_addr, imem_wdata} !== {1'b1, 1'b1, 8'(i % 4), legal_tab[i].exp}) begin
        bad++; $display("FAIL enc[%0d]: acc=%b seen=%b addr=%0d data=%h want 1/1/%0d/%h",
                        i, acc, seen, imem_addr, imem_wdata, i % 4, legal_tab[i].exp); end
    end
    @(negedge clk);
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL enc_err: got %b want 0", err_illegal); end
  endtask

  task automatic test_illegal();
    bit acc, seen;
    for (int i = 0; i < 8; i++) begin
      do_clear();
      send(illegal_tab[i], 4, acc);
      wait_we(3, seen);
      total++; if ({acc, seen, err_illegal, count} !== {1'b1, 1'b0, 1'b1, 9'd0}) begin
        bad++; $display("FAIL illegal[%0d]: acc=%b seen=%b err=%b count=%0d want 1/0/1/0",
                        i, acc, seen, err_illegal, count); end
    end
  endtask

  task automatic test_stall();
    bit acc, seen;
    do_clear();
    imem_ready = 1'b0;
    send(mk(4'd0, 3'b000, 1'b0, 32'd0), 4, acc);
    wait_we(4, seen);
    total++; if ({seen, imem_addr, imem_wdata} !== {1'b1, 8'd0, 32'h002081B3}) begin
      bad++; $display("FAIL stall_start: seen=%b addr=%0d data=%h want 1/0/002081b3", seen, imem_addr, imem_wdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({imem_we, req_ready, imem_addr, imem_wdata, count} !== {1'b1, 1'b0, 8'd0, 32'h002081B3, 9'd0}) begin
        bad++; $display("FAIL stall_hold[%0d]: we=%b rdy=%b addr=%0d data=%h count=%0d want 1/0/0/002081b3/0",
                        i, imem_we, req_ready, imem_addr, imem_wdata, count); end
    end
    imem_ready = 1'b1;
    @(negedge clk);
    total++; if ({imem_we, count} !== {1'b0, 9'd1}) begin
      bad++; $display("FAIL stall_release: we=%b count=%0d want 0/1", imem_we, count); end
  endtask

  task automatic test_clear_mid_write();
    bit acc, seen;
    imem_ready = 1'b0;
    send(mk(4'd0, 3'b000, 1'b1, 32'd0), 4, acc);
    wait_we(4, seen);
    do_clear();
    total++; if ({seen, imem_we, req_ready, count} !== {1'b1, 1'b0, 1'b1, 9'd0}) begin
      bad++; $display("FAIL clear_wr: seen=%b we=%b rdy=%b count=%0d want 1/0/1/0", seen, imem_we, req_ready, count); end
    imem_ready = 1'b1;
    @(negedge clk);
    total++; if ({imem_we, count} !== {1'b0, 9'd0}) begin
      bad++; $display("FAIL clear_wr_after: we=%b count=%0d want 0/0", imem_we, count); end
  endtask

  task automatic test_done();
    bit acc, seen;
    send(mk(4'd15, 3'b000, 1'b0, 32'd0), 4, acc);
    wait_we(3, seen);
    total++; if ({acc, seen, done, req_ready, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 9'd0}) begin
      bad++; $display("FAIL end: acc=%b seen=%b done=%b rdy=%b count=%0d want 1/0/1/0/0",
                      acc, seen, done, req_ready, count); end
    send(mk(4'd0, 3'b000, 1'b0, 32'd0), 4, acc);
    total++; if ({acc, done} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL after_end: acc=%b done=%b want 0/1", acc, done); end
    do_clear();
    total++; if ({done, req_ready} !== 2'b01) begin
      bad++; $display("FAIL end_clear: done=%b rdy=%b want 0/1", done, req_ready); end
  endtask

  task automatic test_async_reset();
    bit acc, seen;
    do_clear();
    send(illegal_tab[0], 4, acc);
    send(mk(4'd0, 3'b000, 1'b0, 32'd0), 4, acc);
    wait_we(4, seen);
    @(negedge clk);
    imem_ready = 1'b0;
    send(mk(4'd0, 3'b000, 1'b1, 32'd0), 4, acc);
    wait_we(4, seen);
    total++; if ({seen, imem_addr, count, err_illegal} !== {1'b1, 8'd1, 9'd1, 1'b1}) begin
      bad++; $display("FAIL pre_rst: seen=%b addr=%0d count=%0d err=%b want 1/1/1/1",
                      seen, imem_addr, count, err_illegal); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({imem_we, count, err_illegal} !== {1'b0, 9'd0, 1'b0}) begin
      bad++; $display("FAIL rst_async: we=%b count=%0d err=%b want 0/0/0", imem_we, count, err_illegal); end
    @(negedge clk); rst_n = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    total++; if ({req_ready, imem_we, done, full, err_illegal, count, imem_addr} !== {5'b10000, 9'd0, 8'd0}) begin
      bad++; $display("FAIL rst_release: flags=%b count=%0d addr=%0d want 10000/0/0",
                      {req_ready, imem_we, done, full, err_illegal}, count, imem_addr); end
  endtask

  task automatic test_imm_range();
    bit acc, seen;
    do_clear();
    send(mk(4'd1, 3'b000, 1'b0, 32'd2048), 4, acc);
    wait_we(3, seen);
`ifdef IMM_RANGE_CHECK_EN
    total++; if ({acc, seen, err_illegal} !== 3'b101) begin
      bad++; $display("FAIL imm2048: acc=%b seen=%b err=%b want 1/0/1", acc, seen, err_illegal); end
`else
    total++; if ({acc, seen, imem_addr, imem_wdata} !== {1'b1, 1'b1, 8'd0, 32'h80000093}) begin
      bad++; $display("FAIL imm2048: acc=%b seen=%b addr=%0d data=%h want 1/1/0/80000093",
                      acc, seen, imem_addr, imem_wdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_illegal_branch();
    test_fill();
    test_encodings();
    test_illegal();
    test_stall();
    test_clear_mid_write();
    test_done();
    test_async_reset();
    test_imm_range();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
